bus_cycle_ctrl: RTL and testbench

//  Parametrised 68000 bus-cycle controller for the SF500 CPU card; successor to the fixed fast-DTACK/speed-switch glue.

---
 rtl/sf500_bus_pkg.sv | 24 ++
 rtl/bus_cycle_ctrl_if.sv | 33 +++
 rtl/bus_cycle_ctrl_sw_debounce.sv | 54 +++++
 rtl/bus_cycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_bus_cycle_ctrl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sf500_bus_pkg.sv
// Shared types and constants for the SF500 bus-cycle controller.
// Bus FSM encoding, default timing constants and an index-width helper.
package sf500_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    EXT  = 2'd3
  } bus_state_e;

  localparam int DEFAULT_TIMEOUT_CYC  = 255;
  localparam int DEFAULT_DEBOUNCE_CYC = 1024;

  // Width of a region index; never below one bit so a single region still has a field.
  function automatic int region_idx_w(input int n_regions);
    if (n_regions <= 1) begin
      return 1;
    end else begin
      return $clog2(n_regions);
    end
  endfunction

endpackage

// File: rtl/bus_cycle_ctrl_if.sv
// 68000 bus-side signal bundle between the CPU card glue and the cycle controller.
// The controller uses the slave modport; the CPU/bus model uses master.
interface bus_cycle_ctrl_if #(
  parameter int N_REGIONS = 4,
  parameter int WS_BITS   = 3
);

  logic                           AS_CPU_n;
  logic [N_REGIONS-1:0]           REGION_HIT;
  logic [N_REGIONS*WS_BITS-1:0]   WAIT_CFG;
  logic                           DTACK_MB_n;
  logic                           M6800_DTACK_n;
  logic                           DTACK_n;

  modport slave (
    input  AS_CPU_n,
    input  REGION_HIT,
    input  WAIT_CFG,
    input  DTACK_MB_n,
    input  M6800_DTACK_n,
    output DTACK_n
  );

  modport master (
    output AS_CPU_n,
    output REGION_HIT,
    output WAIT_CFG,
    output DTACK_MB_n,
    output M6800_DTACK_n,
    input  DTACK_n
  );

endinterface

// File: rtl/bus_cycle_ctrl_sw_debounce.sv
// Two-flop synchroniser plus stability counter for the asynchronous speed switch.
// level_o follows the synchronised input only after STABLE_CYC unchanged clocks.
module sw_debounce #(
  parameter int STABLE_CYC = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sw_i,
  output logic level_o
);

  localparam int CW = $clog2(STABLE_CYC + 1);

  logic [1:0]    sync_q;
  logic          cand_q;
  logic          cand_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          level_q;
  logic          level_d;

  // Synchroniser, candidate level, stability counter and accepted level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      cand_q  <= 1'b1;
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], sw_i};
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  // Any change of the synchronised value restarts the stability count.
  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync_q[1] != cand_q) begin
      cand_d = sync_q[1];
      cnt_d  = '0;
    end else if (cnt_q == CW'(STABLE_CYC)) begin
      level_d = cand_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/bus_cycle_ctrl.sv
// SF500 68000 bus-cycle controller: region decode with per-region wait states, DTACK merge,
// idle-only CPU clock speed switching. Optional watchdog enabled by macro BUSCYC_TIMEOUT_EN.
module bus_cycle_ctrl
  import sf500_bus_pkg::*;
#(
  parameter int N_REGIONS    = 4,
  parameter int WS_BITS      = 3,
  parameter int DEBOUNCE_CYC = DEFAULT_DEBOUNCE_CYC,
  parameter int TIMEOUT_CYC  = DEFAULT_TIMEOUT_CYC
) (
  input  logic              C14M,
  input  logic              RESET_n,
  bus_cycle_ctrl_if.slave   bus,
  input  logic              SW1,
  output logic              SPEED_7M,
  output logic              CYCLE_ACTIVE,
  output logic              TIMEOUT_FLAG
);

  localparam int IDX_W = region_idx_w(N_REGIONS);

  bus_state_e         state_q;
  bus_state_e         state_d;
  logic [WS_BITS-1:0] cnt_q;
  logic [WS_BITS-1:0] cnt_d;
  logic               local_ack_q;
  logic               local_ack_d;
  logic               speed_q;
  logic               speed_d;
  logic               active_q;
  logic               hit_any_s;
  logic [IDX_W-1:0]   hit_idx_s;
  logic [WS_BITS-1:0] ws_sel_s;
  logic               dtack_s;
  logic               speed_pend_s;

`ifdef BUSCYC_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);
  logic [WDW-1:0]     wd_q;
  logic [WDW-1:0]     wd_d;
  logic               wd_fire_s;
  logic               tmo_flag_q;
`endif

  sw_debounce #(
    .STABLE_CYC (DEBOUNCE_CYC)
  ) u_sw1_debounce (
    .clk_i   (C14M),
    .rst_ni  (RESET_n),
    .sw_i    (SW1),
    .level_o (speed_pend_s)
  );

  assign hit_any_s   = |bus.REGION_HIT;
  assign dtack_s     = local_ack_q & bus.DTACK_MB_n & bus.M6800_DTACK_n;
  assign bus.DTACK_n = dtack_s;

  // Lowest set hit index wins: scan downward so the last assignment is the lowest.
  always_comb begin
    hit_idx_s = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (bus.REGION_HIT[i]) begin
        hit_idx_s = IDX_W'(i);
      end else begin
        hit_idx_s = hit_idx_s;
      end
    end
  end

  always_comb begin
    ws_sel_s = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (hit_idx_s == IDX_W'(i)) begin
        ws_sel_s = bus.WAIT_CFG[i*WS_BITS +: WS_BITS];
      end else begin
        ws_sel_s = ws_sel_s;
      end
    end
  end

  // Next state; AS_CPU_n high always returns to IDLE, which also covers mid-cycle aborts.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    local_ack_d = 1'b1;
`ifdef BUSCYC_TIMEOUT_EN
    wd_d        = '0;
    wd_fire_s   = 1'b0;
`endif
    if (bus.AS_CPU_n) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit_any_s) begin
            cnt_d = ws_sel_s;
            if (ws_sel_s == '0) begin
              state_d = ACK;
            end else begin
              state_d = WAIT;
            end
          end else begin
            state_d = EXT;
          end
        end
        WAIT: begin
          if (cnt_q <= WS_BITS'(1)) begin
            cnt_d   = '0;
            state_d = ACK;
          end else begin
            cnt_d = cnt_q - WS_BITS'(1);
          end
        end
        ACK: begin
          local_ack_d = 1'b0;
        end
        EXT: begin
          state_d = EXT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
`ifdef BUSCYC_TIMEOUT_EN
      if ((state_q == WAIT) || (state_q == EXT)) begin
        if (wd_q == WDW'(TIMEOUT_CYC - 1)) begin
          state_d   = ACK;
          cnt_d     = '0;
          wd_fire_s = 1'b1;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end else begin
        wd_d = '0;
      end
`endif
    end
  end

  // Speed select changes only at a true bus-idle edge so CLKCPU never switches mid-cycle.
  always_comb begin
    if ((state_q == IDLE) && bus.AS_CPU_n && dtack_s) begin
      speed_d = speed_pend_s;
    end else begin
      speed_d = speed_q;
    end
  end

  always_ff @(posedge C14M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      local_ack_q <= 1'b1;
      speed_q     <= 1'b1;
      active_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      local_ack_q <= local_ack_d;
      speed_q     <= speed_d;
      active_q    <= (state_d != IDLE);
    end
  end

`ifdef BUSCYC_TIMEOUT_EN
  // Watchdog count and sticky fired flag; only reset clears the flag.
  always_ff @(posedge C14M or negedge RESET_n) begin
    if (!RESET_n) begin
      wd_q       <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      tmo_flag_q <= tmo_flag_q | wd_fire_s;
    end
  end

  assign TIMEOUT_FLAG = tmo_flag_q;
`else
  assign TIMEOUT_FLAG = 1'b0;
`endif

  assign SPEED_7M     = speed_q;
  assign CYCLE_ACTIVE = active_q;

endmodule

// File: tb/tb_bus_cycle_ctrl.sv
// Self-checking bench for bus_cycle_ctrl: directed scenarios plus randomized bus cycles
// compared against a timing model derived from the region/wait-state rules.
module tb_bus_cycle_ctrl;

  localparam int NR   = 4;
  localparam int WSB  = 3;
  localparam int CFGW = NR * WSB;
  localparam int DEB  = 1024;
  localparam int TMO  = 255;

  logic C14M = 1'b0;
  logic RESET_n;
  logic SW1;
  logic SPEED_7M;
  logic CYCLE_ACTIVE;
  logic TIMEOUT_FLAG;

  int checks = 0;
  int errors = 0;

  bus_cycle_ctrl_if #(.N_REGIONS(NR), .WS_BITS(WSB)) bus ();

  bus_cycle_ctrl #(
    .N_REGIONS    (NR),
    .WS_BITS      (WSB),
    .DEBOUNCE_CYC (DEB),
    .TIMEOUT_CYC  (TMO)
  ) dut (
    .C14M         (C14M),
    .RESET_n      (RESET_n),
    .bus          (bus),
    .SW1          (SW1),
    .SPEED_7M     (SPEED_7M),
    .CYCLE_ACTIVE (CYCLE_ACTIVE),
    .TIMEOUT_FLAG (TIMEOUT_FLAG)
  );

  always #5 C14M = ~C14M;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge C14M);
    #1;
  endtask

  // Wait states of the lowest-numbered hit region, or -1 when nothing is decoded.
  function automatic int model_ws(input logic [NR-1:0] hit, input logic [CFGW-1:0] cfg);
    for (int i = 0; i < NR; i++) begin
      if (hit[i]) return int'((cfg >> (i * WSB)) % (1 << WSB));
    end
    return -1;
  endfunction

  // DTACK_n after the e-th edge that sampled AS low (edge 0 is the first).
  function automatic logic model_dtack(input int ws, input int e);
    return (ws >= 0 && e >= ws + 1) ? 1'b0 : 1'b1;
  endfunction

  task automatic run_cycle(input logic [NR-1:0] hit, input logic [CFGW-1:0] cfg,
                           input int hold, input bit scramble, input string tag);
    int ws;
    ws = model_ws(hit, cfg);
    bus.WAIT_CFG   = cfg;
    bus.REGION_HIT = hit;
    bus.AS_CPU_n   = 1'b0;
    for (int e = 0; e < hold; e++) begin
      tick;
      if (scramble) bus.REGION_HIT = NR'($urandom);
      check({tag, "_dtack"}, bus.DTACK_n, model_dtack(ws, e));
      check({tag, "_active"}, CYCLE_ACTIVE, 1'b1);
    end
    bus.AS_CPU_n   = 1'b1;
    bus.REGION_HIT = '0;
    tick;
    check({tag, "_end_dtack"}, bus.DTACK_n, 1'b1);
    check({tag, "_end_active"}, CYCLE_ACTIVE, 1'b0);
  endtask

  initial begin
    logic [CFGW-1:0] cfg;
    logic [NR-1:0]   hit;
    int              hold;
    bit              seen;

    RESET_n           = 1'b0;
    SW1               = 1'b1;
    bus.AS_CPU_n      = 1'b1;
    bus.REGION_HIT    = '0;
    bus.WAIT_CFG      = '0;
    bus.DTACK_MB_n    = 1'b1;
    bus.M6800_DTACK_n = 1'b1;
    repeat (3) tick;
    check("rst_dtack", bus.DTACK_n, 1'b1);
    check("rst_speed", SPEED_7M, 1'b1);
    check("rst_active", CYCLE_ACTIVE, 1'b0);
    check("rst_tmo", TIMEOUT_FLAG, 1'b0);
    RESET_n = 1'b1;
    repeat (2) tick;

    // Region 1 with three wait states: DTACK at edge 4.
    cfg = '0;
    cfg[1*WSB +: WSB] = 3'd3;
    run_cycle(4'b0010, cfg, 7, 1'b0, "t1_ws3");

    // Region 0 zero wait states, then overlapping hits with region 1 winning.
    cfg = '0;
    run_cycle(4'b0001, cfg, 3, 1'b0, "t2_ws0");
    cfg[1*WSB +: WSB] = 3'd2;
    cfg[2*WSB +: WSB] = 3'd5;
    run_cycle(4'b0110, cfg, 6, 1'b0, "t2_prio");

    // No hit: motherboard DTACK passes straight through, local ack never asserted.
    bus.REGION_HIT = '0;
    bus.AS_CPU_n   = 1'b0;
    for (int e = 0; e < 6; e++) begin
      tick;
      check("t3_pre", bus.DTACK_n, 1'b1);
    end
    bus.DTACK_MB_n = 1'b0;
    #1;
    check("t3_mb_comb", bus.DTACK_n, 1'b0);
    tick;
    check("t3_mb_edge", bus.DTACK_n, 1'b0);
    bus.DTACK_MB_n = 1'b1;
    #1;
    check("t3_local", bus.DTACK_n, 1'b1);
    bus.M6800_DTACK_n = 1'b0;
    #1;
    check("t3_6800", bus.DTACK_n, 1'b0);
    bus.M6800_DTACK_n = 1'b1;
    bus.AS_CPU_n      = 1'b1;
    tick;
    check("t3_idle", CYCLE_ACTIVE, 1'b0);

    // Abort in WAIT with two counts left.
    cfg = '0;
    cfg[2*WSB +: WSB] = 3'd4;
    run_cycle(4'b0100, cfg, 3, 1'b0, "t4_abort");
    tick;
    check("t4_after", bus.DTACK_n, 1'b1);

    // Randomized cycles; hits changed after decode must not matter.
    for (int n = 0; n < 40; n++) begin
      cfg  = CFGW'($urandom);
      hit  = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
      hold = $urandom_range(1, 12);
      run_cycle(hit, cfg, hold, bit'($urandom_range(0, 1)), "rnd");
      repeat ($urandom_range(0, 3)) tick;
    end

    // A 500-cycle glitch on SW1 is filtered.
    SW1  = 1'b0;
    repeat (500) tick;
    SW1  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      tick;
      if (SPEED_7M !== 1'b1) seen = 1'b1;
    end
    check("t5_glitch", {31'd0, seen}, 32'd0);

    // Speed request completes during a long WS=7 cycle, applies at the first idle edge.
    SW1 = 1'b0;
    cfg = '0;
    cfg[3*WSB +: WSB] = 3'd7;
    bus.WAIT_CFG   = cfg;
    bus.REGION_HIT = 4'b1000;
    bus.AS_CPU_n   = 1'b0;
    for (int e = 0; e < 1200; e++) begin
      tick;
      if (e == 7) check("t5_ws7_pre", bus.DTACK_n, 1'b1);
      if (e == 8) check("t5_ws7_ack", bus.DTACK_n, 1'b0);
    end
    check("t5_hold_speed", SPEED_7M, 1'b1);
    check("t5_hold_active", CYCLE_ACTIVE, 1'b1);
    bus.AS_CPU_n   = 1'b1;
    bus.REGION_HIT = '0;
    tick;
    check("t5_ack_edge", SPEED_7M, 1'b1);
    tick;
    check("t5_idle_edge", SPEED_7M, 1'b0);
    SW1  = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < DEB + 20; i++) begin
      tick;
      if (SPEED_7M === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("t5_back_7m", {31'd0, seen}, 32'd1);

`ifdef BUSCYC_TIMEOUT_EN
    // Hung external cycle: watchdog terminates it and the flag sticks until reset.
    bus.REGION_HIT = '0;
    bus.AS_CPU_n   = 1'b0;
    for (int e = 0; e <= TMO + 1; e++) begin
      tick;
      if (e >= TMO - 1) check("t6_wd_dtack", bus.DTACK_n, model_dtack(TMO, e));
    end
    check("t6_flag", TIMEOUT_FLAG, 1'b1);
    bus.AS_CPU_n = 1'b1;
    tick;
    check("t6_release", bus.DTACK_n, 1'b1);
    cfg = '0;
    run_cycle(4'b0001, cfg, 3, 1'b0, "t6_next");
    check("t6_sticky", TIMEOUT_FLAG, 1'b1);
    RESET_n = 1'b0;
    #1;
    check("t6_clear", TIMEOUT_FLAG, 1'b0);
    RESET_n = 1'b1;
    tick;
`else
    // Without the watchdog an unanswered external cycle simply waits.
    bus.REGION_HIT = '0;
    bus.AS_CPU_n   = 1'b0;
    seen = 1'b0;
    for (int e = 0; e < TMO + 45; e++) begin
      tick;
      if (bus.DTACK_n !== 1'b1) seen = 1'b1;
    end
    check("t6_no_wd", {31'd0, seen}, 32'd0);
    check("t6_no_flag", TIMEOUT_FLAG, 1'b0);
    check("t6_still_active", CYCLE_ACTIVE, 1'b1);
    bus.AS_CPU_n = 1'b1;
    tick;
    check("t6_release", CYCLE_ACTIVE, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
